mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as the responder on the core's data-memory bus (Address / WriteData / Read / Write / ReadData). The core stores bytes into a TX FIFO. An 8N1 serializer drains the FIFO onto a tx pin. Status and control are readable and writable through the same bus. It sits beside the data memory; the top-level selects ReadData from this block when Hit is high.

---
 rtl/mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, responding on the core's data bus.
// Define MMIO_UART_PARITY_EN to add an even-parity bit (11-bit frame, STATUS[11]=1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        Write,
  input  logic        Read,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef MMIO_UART_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef MMIO_UART_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          en_q, irq_en_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic [1:0]  off_s;
  logic        wr_txdata_s, wr_status_s, wr_ctrl_s;
  logic        full_s, empty_s, busy_s, push_s, pop_s, baud_last_s;
  logic [31:0] status_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign Hit         = (Address[31:4] == BASE_ADDR[31:4]);
  assign off_s       = Address[3:2];
  assign wr_txdata_s = Write && Hit && (off_s == 2'd0);
  assign wr_status_s = Write && Hit && (off_s == 2'd1);
  assign wr_ctrl_s   = Write && Hit && (off_s == 2'd2);

  assign full_s      = (count_q == CW'(FIFO_DEPTH));
  assign empty_s     = (count_q == {CW{1'b0}});
  assign busy_s      = (state_q != S_IDLE);
  // Fullness is judged before the same-cycle pop, so a push into a full FIFO is always dropped.
  assign push_s      = wr_txdata_s && !full_s;
  assign pop_s       = (state_q == S_IDLE) && en_q && !empty_s;
  assign baud_last_s = (baud_q == BW'(CLKS_PER_BIT - 1));

  assign status_s = {20'd0, PAR_FLAG, 7'(count_q), ovf_q, busy_s, empty_s, full_s};
  assign unused_s = ^{WriteData[31:8], Address[1:0]};

  // Zero-wait-state register read mux.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (Read && Hit) begin
      case (off_s)
        2'd1:    rdata_s = status_s;
        2'd2:    rdata_s = {30'd0, irq_en_q, en_q};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign ReadData = rdata_s;
  assign tx       = tx_q;
  assign irq      = irq_en_q && empty_s && !busy_s;

  // FIFO occupancy and sticky overflow next-state.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_txdata_s && full_s) begin
      ovf_d = 1'b1;
    end else if (wr_status_s && WriteData[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= WriteData[7:0];
    end
  end

  // FIFO pointers, count, overflow and CTRL register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_ctrl_s) begin
        en_q     <= WriteData[0];
        irq_en_q <= WriteData[1];
      end
    end
  end

  // Serializer next-state; tx is computed from the next state so the pin is registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        baud_d = {BW{1'b0}};
        if (pop_s) begin
          shift_d = mem_q[rd_ptr_q];
          par_d   = ^mem_q[rd_ptr_q];
          bit_d   = 3'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_last_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last_s) begin
          baud_d  = {BW{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        if (baud_last_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_last_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        baud_d  = {BW{1'b0}};
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Serializer state register; reset drives tx high without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4); frame timing follows MMIO_UART_PARITY_EN.
module tb_mmio_uart_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;
`ifdef MMIO_UART_PARITY_EN
  localparam int          FRAME = 44;
  localparam logic [31:0] PBIT  = 32'h0000_0800;
`else
  localparam int          FRAME = 40;
  localparam logic [31:0] PBIT  = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        Write;
  logic        Read;
  logic [31:0] ReadData;
  logic        Hit;
  logic        tx;
  logic        irq;

  int total = 0;
  int bad   = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0400),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .Write    (Write),
    .Read     (Read),
    .ReadData (ReadData),
    .Hit      (Hit),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address   = a;
    WriteData = d;
    Write     = 1'b1;
    @(posedge clk);
    #1;
    Write   = 1'b0;
    Address = 32'h0;
  endtask

  // Combinational read inside the low clock phase.
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    Address = a;
    Read    = 1'b1;
    #1;
    d       = ReadData;
    h       = Hit;
    Read    = 1'b0;
    Address = 32'h0;
  endtask

  // Expected tx per cycle: start, 8 data bits LSB first, optional parity, stop, one idle cycle.
  function automatic logic [63:0] frame_exp(input logic [7:0] b);
    logic [63:0] e;
    e = '1;
    for (int j = 0; j < CPB; j++) e[j] = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < CPB; j++) e[CPB + i*CPB + j] = b[i];
`ifdef MMIO_UART_PARITY_EN
    for (int j = 0; j < CPB; j++) e[9*CPB + j] = ^b;
`endif
    return e;
  endfunction

  function automatic logic [63:0] busy_exp();
    logic [63:0] e;
    e = '0;
    for (int k = 0; k < FRAME; k++) e[k] = 1'b1;
    return e;
  endfunction

  task automatic capture(output logic [63:0] txv, output logic [63:0] bv, output logic [63:0] iv);
    logic [31:0] st;
    logic        h;
    txv = '1;
    bv  = '0;
    iv  = '0;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      bus_rd(32'h404, st, h);
      txv[k] = tx;
      bv[k]  = st[2];
      iv[k]  = irq;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    reset = 1'b0; Address = 32'h0; WriteData = 32'h0; Write = 1'b0; Read = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_rd(32'h404, d, h);
    total++; if (d !== (32'h2 | PBIT)) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h2 | PBIT); end
    total++; if (h !== 1'b1) begin bad++; $display("FAIL reset_hit got=%b exp=1", h); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_rd(32'h410, d, h);
    total++; if (h !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL miss_decode hit=%b data=%h exp hit=0 data=0", h, d); end
    bus_rd(32'h408, d, h);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic        h;
    logic [63:0] txv, bv, iv;
    bus_wr(32'h408, 32'h1);
    bus_wr(32'h400, 32'hA5);
    @(negedge clk);
    bus_rd(32'h404, d, h);
    total++; if (d !== (32'h10 | PBIT)) begin bad++; $display("FAIL pre_frame_status got=%h exp=%h", d, 32'h10 | PBIT); end
    bus_rd(32'h400, d, h);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_reads_zero got=%h exp=0", d); end
    capture(txv, bv, iv);
    total++; if (txv !== frame_exp(8'hA5)) begin bad++; $display("FAIL frame_a5 got=%h exp=%h", txv, frame_exp(8'hA5)); end
    total++; if (bv !== busy_exp()) begin bad++; $display("FAIL busy_a5 got=%h exp=%h", bv, busy_exp()); end
    @(negedge clk);
    bus_rd(32'h404, d, h);
    total++; if (d !== (32'h2 | PBIT)) begin bad++; $display("FAIL post_frame_status got=%h exp=%h", d, 32'h2 | PBIT); end
  endtask

  task automatic test_overflow_back_to_back();
    logic [31:0] d;
    logic        h;
    logic [63:0] txv, bv, iv;
    logic        idle_ok;
    bus_wr(32'h408, 32'h0);
    for (int i = 0; i < 5; i++) bus_wr(32'h400, 32'h11 + i);
    @(negedge clk);
    bus_rd(32'h404, d, h);
    total++; if (d !== (32'h49 | PBIT)) begin bad++; $display("FAIL overflow_status got=%h exp=%h", d, 32'h49 | PBIT); end
    bus_wr(32'h404, 32'h8);
    @(negedge clk);
    bus_rd(32'h404, d, h);
    total++; if (d !== (32'h41 | PBIT)) begin bad++; $display("FAIL overflow_clear got=%h exp=%h", d, 32'h41 | PBIT); end
    bus_wr(32'h408, 32'h1);
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      capture(txv, bv, iv);
      total++; if (txv !== frame_exp(8'h11 + f[7:0])) begin bad++; $display("FAIL b2b_frame%0d got=%h exp=%h", f, txv, frame_exp(8'h11 + f[7:0])); end
      total++; if (bv !== busy_exp()) begin bad++; $display("FAIL b2b_busy%0d got=%h exp=%h", f, bv, busy_exp()); end
    end
    idle_ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) idle_ok = 1'b0;
    end
    total++; if (idle_ok !== 1'b1) begin bad++; $display("FAIL dropped_byte_sent got=0 exp=1 (tx idle)"); end
    bus_rd(32'h404, d, h);
    total++; if (d !== (32'h2 | PBIT)) begin bad++; $display("FAIL drained_status got=%h exp=%h", d, 32'h2 | PBIT); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        h;
    logic [63:0] txv, bv, iv;
    bus_wr(32'h408, 32'h3);
    @(negedge clk);
    bus_rd(32'h408, d, h);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL ctrl_readback got=%h exp=3", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_idle_empty got=%b exp=1", irq); end
    bus_wr(32'h400, 32'h3C);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_pending got=%b exp=0", irq); end
    capture(txv, bv, iv);
    total++; if (iv !== (64'd1 << FRAME)) begin bad++; $display("FAIL irq_frame got=%h exp=%h", iv, 64'd1 << FRAME); end
    total++; if (txv !== frame_exp(8'h3C)) begin bad++; $display("FAIL frame_3c got=%h exp=%h", txv, frame_exp(8'h3C)); end
    bus_wr(32'h408, 32'h1);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_disabled got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic        h;
    logic        idle_ok;
    bus_wr(32'h400, 32'h00);
    bus_wr(32'h400, 32'h5A);
    repeat (10) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_data_tx got=%b exp=0", tx); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx got=%b exp=1", tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_reset_irq got=%b exp=0", irq); end
    @(negedge clk);
    reset = 1'b1;
    bus_rd(32'h404, d, h);
    total++; if (d !== (32'h2 | PBIT)) begin bad++; $display("FAIL after_reset_status got=%h exp=%h", d, 32'h2 | PBIT); end
    bus_wr(32'h408, 32'h1);
    idle_ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) idle_ok = 1'b0;
    end
    total++; if (idle_ok !== 1'b1) begin bad++; $display("FAIL residual_frame got=0 exp=1 (tx idle)"); end
  endtask

  task automatic test_parity();
    logic [31:0] d;
    logic        h;
    logic [63:0] txv, bv, iv;
    bus_wr(32'h400, 32'h07);
    @(negedge clk);
    bus_rd(32'h404, d, h);
    total++; if (d[11] !== PBIT[11]) begin bad++; $display("FAIL status_parity_flag got=%b exp=%b", d[11], PBIT[11]); end
    capture(txv, bv, iv);
    total++; if (txv !== frame_exp(8'h07)) begin bad++; $display("FAIL frame_07 got=%h exp=%h", txv, frame_exp(8'h07)); end
    total++; if (bv !== busy_exp()) begin bad++; $display("FAIL busy_07 got=%h exp=%h", bv, busy_exp()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow_back_to_back();
    test_irq();
    test_reset_mid_frame();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
